pipe_skid_stage: RTL and testbench

//  Generic, parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) carrying one packed bundle.

---
 rtl/pipe_skid_stage_pkg.sv | 25 ++
 rtl/pipe_skid_stage.sv | 119 +++++++++++
 tb/tb_pipe_skid_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the inter-stage pipeline register: state encoding
// and the state-to-occupancy mapping.
package pipe_skid_stage_pkg;

  // State encoding doubles as the occupancy count (0, 1 or 2 entries held).
  typedef enum logic [1:0] {
    PIPE_ST_EMPTY = 2'd0,
    PIPE_ST_ONE   = 2'd1,
    PIPE_ST_FULL  = 2'd2
  } pipe_st_e;

  localparam int PIPE_OCC_W = 2;

  // Number of bundles held in a given state.
  function automatic logic [PIPE_OCC_W-1:0] pipe_occ(input pipe_st_e st);
    logic [PIPE_OCC_W-1:0] occ;
    case (st)
      PIPE_ST_ONE:  occ = 2'd1;
      PIPE_ST_FULL: occ = 2'd2;
      default:      occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry
// skid buffer, flush and a retire counter. The main register is always the
// head of the stage; the skid register catches the bundle accepted while the
// downstream stage stalls, so in_ready never depends on out_ready.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SKID_EN    = 1,
  parameter int CLR_ON_POP = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk_Pipe,
  input  logic              rst_n_Pipe,
  input  logic              flush_Pipe,
  input  logic              in_valid_Pipe,
  output logic              in_ready_Pipe,
  input  logic [DATA_W-1:0] in_data_Pipe,
  output logic              out_valid_Pipe,
  input  logic              out_ready_Pipe,
  output logic [DATA_W-1:0] out_data_Pipe,
  output logic [1:0]        occ_Pipe,
  output logic [CNT_W-1:0]  retire_cnt_Pipe
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pipe_st_e          state_reg, state_next;
  logic [DATA_W-1:0] main_reg, main_next;
  logic [DATA_W-1:0] skid_reg, skid_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              in_fire, out_fire;

  // Reset masks both handshake outputs so neither side sees a transfer.
  assign out_valid_Pipe  = rst_n_Pipe & (state_reg != PIPE_ST_EMPTY);
  assign out_data_Pipe   = main_reg;
  assign occ_Pipe        = pipe_occ(state_reg);
  assign retire_cnt_Pipe = cnt_reg;

  assign in_fire  = in_valid_Pipe & in_ready_Pipe;
  assign out_fire = out_valid_Pipe & out_ready_Pipe;

  generate
    if (SKID_EN != 0) begin : g_skid
      // Ready comes from state only: the skid slot absorbs the in-flight bundle.
      assign in_ready_Pipe = rst_n_Pipe & (state_reg != PIPE_ST_FULL);
    end else begin : g_single
      // Single entry: can accept when empty or when the head leaves this cycle.
      assign in_ready_Pipe = rst_n_Pipe & ((state_reg == PIPE_ST_EMPTY) | out_ready_Pipe);
    end
  endgenerate

  // Next-state and data-path selection; flush overrides every transition.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush_Pipe) begin
      state_next = PIPE_ST_EMPTY;
      if (CLR_ON_POP != 0) begin
        main_next = '0;
        skid_next = '0;
      end
    end else begin
      case (state_reg)
        PIPE_ST_EMPTY: begin
          if (in_fire) begin
            state_next = PIPE_ST_ONE;
            main_next  = in_data_Pipe;
          end
        end
        PIPE_ST_ONE: begin
          if (in_fire && out_fire) begin
            main_next = in_data_Pipe;
          end else if (in_fire && (SKID_EN != 0)) begin
            state_next = PIPE_ST_FULL;
            skid_next  = in_data_Pipe;
          end else if (out_fire) begin
            state_next = PIPE_ST_EMPTY;
            if (CLR_ON_POP != 0) main_next = '0;
          end
        end
        PIPE_ST_FULL: begin
          if (out_fire) begin
            state_next = PIPE_ST_ONE;
            main_next  = skid_reg;
            if (CLR_ON_POP != 0) skid_next = '0;
          end
        end
        default: begin
          state_next = PIPE_ST_EMPTY;
        end
      endcase
    end
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk_Pipe) begin
    if (!rst_n_Pipe) begin
      state_reg <= PIPE_ST_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  // Retire counter: one per output handshake, flush included, wraps naturally.
  always_ff @(posedge clk_Pipe) begin
    if (!rst_n_Pipe) begin
      cnt_reg <= '0;
    end else if (out_fire) begin
      cnt_reg <= cnt_reg + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: main skid instance, a 4-bit counter
// instance sharing its stimulus, and a SKID_EN=0 instance.
module tb_pipe_skid_stage;

  logic        clk;
  logic        rst_n;
  logic        flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occ;
  logic [15:0] cnt;

  logic        w_in_ready, w_out_valid;
  logic [31:0] w_out_data;
  logic [1:0]  w_occ;
  logic [3:0]  w_cnt;

  logic        s_flush, s_in_valid, s_out_ready;
  logic [31:0] s_in_data;
  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_occ;
  logic [15:0] s_cnt;

  int          total = 0;
  int          bad = 0;
  bit          mon_en = 0;
  logic [31:0] exp_q[$];

  pipe_skid_stage u_dut (
    .clk_Pipe(clk), .rst_n_Pipe(rst_n), .flush_Pipe(flush),
    .in_valid_Pipe(in_valid), .in_ready_Pipe(in_ready), .in_data_Pipe(in_data),
    .out_valid_Pipe(out_valid), .out_ready_Pipe(out_ready), .out_data_Pipe(out_data),
    .occ_Pipe(occ), .retire_cnt_Pipe(cnt)
  );

  pipe_skid_stage #(.CNT_W(4)) u_wrap (
    .clk_Pipe(clk), .rst_n_Pipe(rst_n), .flush_Pipe(flush),
    .in_valid_Pipe(in_valid), .in_ready_Pipe(w_in_ready), .in_data_Pipe(in_data),
    .out_valid_Pipe(w_out_valid), .out_ready_Pipe(out_ready), .out_data_Pipe(w_out_data),
    .occ_Pipe(w_occ), .retire_cnt_Pipe(w_cnt)
  );

  pipe_skid_stage #(.SKID_EN(0)) u_single (
    .clk_Pipe(clk), .rst_n_Pipe(rst_n), .flush_Pipe(s_flush),
    .in_valid_Pipe(s_in_valid), .in_ready_Pipe(s_in_ready), .in_data_Pipe(s_in_data),
    .out_valid_Pipe(s_out_valid), .out_ready_Pipe(s_out_ready), .out_data_Pipe(s_out_data),
    .occ_Pipe(s_occ), .retire_cnt_Pipe(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for the main instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("mon_occ", 32'(occ), 32'(exp_q.size()));
      chk("mon_rdy", 32'(in_ready), 32'(exp_q.size() < 2));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("mon_underflow", 32'd1, 32'd0);
        else chk("mon_data", out_data, exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b1;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = 32'h0; s_out_ready = 1'b0;

    // T1 reset
    repeat (3) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_wcnt", 32'(w_cnt), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    mon_en = 1'b1;
    step();

    // T2 streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    chk("t2_cnt", 32'(cnt), 32'd8);

    // T3 backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; step();
    in_data = 32'hB; step();
    in_valid = 1'b0;
    chk("t3_occ2", 32'(occ), 32'd2);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_head", out_data, 32'hA);
    step();
    chk("t3_hold", out_data, 32'hA);
    out_ready = 1'b1;
    step();
    chk("t3_occ1", 32'(occ), 32'd1);
    chk("t3_head_b", out_data, 32'hB);
    step();
    chk("t3_occ0", 32'(occ), 32'd0);
    chk("t3_clr", out_data, 32'd0);
    chk("t3_cnt", 32'(cnt), 32'd10);

    // T4 flush while full, with a downstream pop and a blocked input
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hC; step();
    in_data = 32'hD; step();
    flush = 1'b1; in_data = 32'hE; out_ready = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_occ", 32'(occ), 32'd0);
    chk("t4_cnt", 32'(cnt), 32'd11);
    chk("t4_clr", out_data, 32'd0);
    // flush in ONE drops an accepted input
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hF; step();
    in_data = 32'h10; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4b_occ", 32'(occ), 32'd0);
    chk("t4b_cnt", 32'(cnt), 32'd11);
    step();
    chk("t4b_valid", 32'(out_valid), 32'd0);

    // T5 counter wrap on the 4-bit instance
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 32'h20 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    chk("t5_cnt", 32'(cnt), 32'd17);
    chk("t5_wrap", 32'(w_cnt), 32'd1);

    // T6 single-entry mode
    s_in_valid = 1'b1; s_in_data = 32'h4; s_out_ready = 1'b0; step();
    s_in_valid = 1'b0;
    chk("t6_occ1", 32'(s_occ), 32'd1);
    chk("t6_stall_rdy", 32'(s_in_ready), 32'd0);
    s_out_ready = 1'b1; s_in_valid = 1'b1; s_in_data = 32'h5;
    #1;
    chk("t6_pass_rdy", 32'(s_in_ready), 32'd1);
    chk("t6_head4", s_out_data, 32'h4);
    step();
    chk("t6_head5", s_out_data, 32'h5);
    chk("t6_occ", 32'(s_occ), 32'd1);
    for (int i = 0; i < 6; i++) begin
      s_in_data = 32'h30 + 32'(i);
      s_out_ready = ((i % 2) == 0);
      step();
      chk("t6_occmax", 32'(s_occ <= 2'd1), 32'd1);
    end
    chk("t6_last", s_out_data, 32'h34);
    s_in_valid = 1'b0; s_out_ready = 1'b1;
    step(); step();
    chk("t6_empty", 32'(s_occ), 32'd0);
    chk("t6_cnt", 32'(s_cnt), 32'd5);

    mon_en = 1'b0;
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
